// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: descriptor op codes, fixed opcode fields and
// the encoder's sequencing states.
package legv8_pkg;

    typedef enum logic [3:0] {
        ADDI = 4'd0,
        ADDS = 4'd1,
        AND  = 4'd2,
        EOR  = 4'd3,
        SUBS = 4'd4,
        LSR  = 4'd5,
        LDUR = 4'd6,
        STUR = 4'd7,
        B    = 4'd8,
        BLT  = 4'd9,
        CBZ  = 4'd10
    } op_e;

    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [10:0] OPC_ADDS = 11'b10101011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_EOR  = 11'b11001010000;
    localparam logic [10:0] OPC_SUBS = 11'b11101011000;
    localparam logic [10:0] OPC_LSR  = 11'b11010011010;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [5:0]  OPC_B    = 6'b000101;
    localparam logic [7:0]  OPC_BCND = 8'b01010100;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [4:0]  COND_LT  = 5'b01011;

    // Branch-to-self: B with a zero offset.
    localparam logic [31:0] HALT_WORD = 32'h14000000;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        HALT = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/instr_encode.sv
// Combinational LEGv8 encoder: op plus fields to a 32-bit machine word.
// Op codes outside op_e raise illegal and produce a zero word.
module instr_encode
    import legv8_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [25:0] imm,
    input  logic [5:0]  shamt,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = 32'h0;
        illegal = 1'b0;
        case (op)
            ADDI: word = {OPC_ADDI, imm[11:0], rn, rd};
            ADDS: word = {OPC_ADDS, rm, 6'b0, rn, rd};
            AND:  word = {OPC_AND, rm, 6'b0, rn, rd};
            EOR:  word = {OPC_EOR, rm, 6'b0, rn, rd};
            SUBS: word = {OPC_SUBS, rm, 6'b0, rn, rd};
            LSR:  word = {OPC_LSR, 5'b0, shamt, rn, rd};
            LDUR: word = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
            STUR: word = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
            B:    word = {OPC_B, imm[25:0]};
            BLT:  word = {OPC_BCND, imm[18:0], COND_LT};
            CBZ:  word = {OPC_CBZ, imm[18:0], rd};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_stream_encoder.sv
// Streams encoded LEGv8 words into instruction memory; a finish request
// appends a halt and locks the block until reset.
module instr_stream_encoder
    import legv8_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             op,
    input  logic [4:0]             rd,
    input  logic [4:0]             rn,
    input  logic [4:0]             rm,
    input  logic [25:0]            imm,
    input  logic [5:0]             shamt,
    input  logic                   finish,
    output logic                   wr_en,
    output logic [63:0]            wr_addr,
    output logic [31:0]            wr_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    // The last word stays free so the halt always fits.
    localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   addr_q, addr_d;
    logic          wr_en_q, wr_en_d;
    logic [63:0]   wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic          err_q, err_d;

    logic [31:0]   enc_word;
    logic          enc_illegal;
    logic          accept;

    instr_encode u_encode (
        .op      (op),
        .rd      (rd),
        .rn      (rn),
        .rm      (rm),
        .imm     (imm),
        .shamt   (shamt),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign in_ready = (state_q == LOAD) && (count_q < COUNT_MAX) && !reset;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = err_q;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    if (enc_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = enc_word;
                        addr_d    = addr_q + 64'd4;
                        count_d   = count_q + 1'b1;
                    end
                end
                if (finish) state_d = HALT;
            end
            HALT: begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = HALT_WORD;
                addr_d    = addr_q + 64'd4;
                count_d   = count_q + 1'b1;
                state_d   = DONE;
            end
            DONE: ;
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= LOAD;
            count_q   <= '0;
            addr_q    <= BASE_ADDR;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 64'h0;
            wr_data_q <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign count   = count_q;
    assign done    = (state_q == DONE);
    assign err     = err_q;

endmodule
